// File: rtl/alu_pkg.sv
// Shared ALU opcode encoding and legality check for the ALU arbiter.
package alu_pkg;

    localparam int ALU_OP_W = 6;

    localparam logic [ALU_OP_W-1:0] ALU_ADD  = 6'd1;
    localparam logic [ALU_OP_W-1:0] ALU_SUB  = 6'd2;
    localparam logic [ALU_OP_W-1:0] ALU_XOR  = 6'd3;
    localparam logic [ALU_OP_W-1:0] ALU_OR   = 6'd4;
    localparam logic [ALU_OP_W-1:0] ALU_AND  = 6'd5;
    localparam logic [ALU_OP_W-1:0] ALU_SLL  = 6'd6;
    localparam logic [ALU_OP_W-1:0] ALU_SRA  = 6'd7;
    localparam logic [ALU_OP_W-1:0] ALU_SRL  = 6'd8;
    localparam logic [ALU_OP_W-1:0] ALU_SLT  = 6'd9;
    localparam logic [ALU_OP_W-1:0] ALU_SLTU = 6'd10;

    // Takes the op zero-extended to 32 bits so callers with any op width can use it.
    function automatic logic alu_op_legal(input logic [31:0] op);
        return (op >= 32'(ALU_ADD)) && (op <= 32'(ALU_SLTU));
    endfunction

endpackage

// File: rtl/alu_arbiter_if.sv
// Requester, ALU and result signals of the shared-ALU arbiter.
interface alu_arbiter_if
    import alu_pkg::*;
#(
    parameter int NREQ = 2,
    parameter int XLEN = 32,
    parameter int OPW  = ALU_OP_W,
    parameter int TAGW = 4
);
    localparam int IDW = $clog2(NREQ);

    logic [NREQ-1:0]      req_valid;
    logic [NREQ-1:0]      req_ready;
    logic [NREQ*OPW-1:0]  req_op;
    logic [NREQ*XLEN-1:0] req_a;
    logic [NREQ*XLEN-1:0] req_b;
    logic [NREQ*TAGW-1:0] req_tag;

    logic [OPW-1:0]       alu_op;
    logic [XLEN-1:0]      alu_rd1;
    logic [XLEN-1:0]      alu_rd2;
    logic [XLEN-1:0]      alu_wd;

    logic                 res_valid;
    logic                 res_ready;
    logic [XLEN-1:0]      res_data;
    logic [IDW-1:0]       res_id;
    logic [TAGW-1:0]      res_tag;
    logic                 res_err;

    modport slave (
        input  req_valid, req_op, req_a, req_b, req_tag, alu_wd, res_ready,
        output req_ready, alu_op, alu_rd1, alu_rd2,
        output res_valid, res_data, res_id, res_tag, res_err
    );

    modport master (
        output req_valid, req_op, req_a, req_b, req_tag, alu_wd, res_ready,
        input  req_ready, alu_op, alu_rd1, alu_rd2,
        input  res_valid, res_data, res_id, res_tag, res_err
    );

endinterface

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: search starts at i_ptr and wraps, first request wins.
module rr_arbiter #(
    parameter int NREQ = 2,
    parameter int IDW  = $clog2(NREQ)
) (
    input  logic [NREQ-1:0] i_req,
    input  logic [IDW-1:0]  i_ptr,
    input  logic            i_en,
    output logic [NREQ-1:0] o_grant,
    output logic [IDW-1:0]  o_grant_idx
);

    logic w_found;
    int   w_j;

    always_comb begin
        o_grant     = '0;
        o_grant_idx = '0;
        w_found     = 1'b0;
        w_j         = 0;
        for (int k = 0; k < NREQ; k++) begin
            w_j = (int'(i_ptr) + k) % NREQ;
            if (i_en && !w_found && i_req[w_j]) begin
                o_grant[w_j] = 1'b1;
                o_grant_idx  = w_j[IDW-1:0];
                w_found      = 1'b1;
            end
        end
    end

endmodule

// File: rtl/alu_arbiter.sv
// Shares one combinational ALU between NREQ requesters with round-robin grant and a registered result.
module alu_arbiter
    import alu_pkg::*;
#(
    parameter int NREQ = 2,
    parameter int XLEN = 32,
    parameter int OPW  = ALU_OP_W,
    parameter int TAGW = 4
) (
    input  logic          clk,
    input  logic          rst,
    alu_arbiter_if.slave  bus
);

    localparam int IDW = $clog2(NREQ);

    logic [NREQ-1:0] w_grant;
    logic [IDW-1:0]  w_grant_idx;
    logic [IDW-1:0]  w_next_ptr;
    logic            w_accept_en;
    logic            w_hs;
    logic            w_legal;
    logic [OPW-1:0]  w_op;
    logic [XLEN-1:0] w_a;
    logic [XLEN-1:0] w_b;
    logic [TAGW-1:0] w_tag;

    logic [IDW-1:0]  r_rr_ptr;
    logic            r_vld_p1;
    logic [XLEN-1:0] r_data_p1;
    logic [IDW-1:0]  r_id_p1;
    logic [TAGW-1:0] r_tag_p1;
    logic            r_err_p1;

    // The result slot can take a new op when empty or being drained this cycle; never during reset.
    assign w_accept_en = (!r_vld_p1 || bus.res_ready) && !rst;

    rr_arbiter #(
        .NREQ (NREQ),
        .IDW  (IDW)
    ) u_rr_arbiter (
        .i_req       (bus.req_valid),
        .i_ptr       (r_rr_ptr),
        .i_en        (w_accept_en),
        .o_grant     (w_grant),
        .o_grant_idx (w_grant_idx)
    );

    assign w_hs = |w_grant;

    always_comb begin
        w_op  = '0;
        w_a   = '0;
        w_b   = '0;
        w_tag = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (w_grant[i]) begin
                w_op  = bus.req_op[i*OPW +: OPW];
                w_a   = bus.req_a[i*XLEN +: XLEN];
                w_b   = bus.req_b[i*XLEN +: XLEN];
                w_tag = bus.req_tag[i*TAGW +: TAGW];
            end
        end
    end

    always_comb begin
        w_legal = alu_op_legal(32'(w_op));
        if (int'(w_grant_idx) == NREQ - 1) begin
            w_next_ptr = '0;
        end else begin
            w_next_ptr = w_grant_idx + IDW'(1);
        end
    end

    // Stage p0 -> p1: capture the ALU result of the granted request.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_rr_ptr  <= '0;
            r_vld_p1  <= 1'b0;
            r_data_p1 <= '0;
            r_id_p1   <= '0;
            r_tag_p1  <= '0;
            r_err_p1  <= 1'b0;
        end else if (w_hs) begin
            r_rr_ptr  <= w_next_ptr;
            r_vld_p1  <= 1'b1;
            r_id_p1   <= w_grant_idx;
            r_tag_p1  <= w_tag;
            r_data_p1 <= w_legal ? bus.alu_wd : '0;
            r_err_p1  <= !w_legal;
        end else if (r_vld_p1 && bus.res_ready) begin
            r_vld_p1  <= 1'b0;
        end
    end

    assign bus.req_ready = w_grant;
    assign bus.alu_op    = w_op;
    assign bus.alu_rd1   = w_a;
    assign bus.alu_rd2   = w_b;
    assign bus.res_valid = r_vld_p1;
    assign bus.res_data  = r_data_p1;
    assign bus.res_id    = r_id_p1;
    assign bus.res_tag   = r_tag_p1;
    assign bus.res_err   = r_err_p1;

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed table-driven bench for alu_arbiter with a behavioural ALU on the alu_* port.
module tb_alu_arbiter;
    import alu_pkg::*;

    logic clk;
    logic rst;

    alu_arbiter_if #(.NREQ(2), .XLEN(32), .OPW(6), .TAGW(4)) bus_if ();

    alu_arbiter #(.NREQ(2), .XLEN(32), .OPW(6), .TAGW(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural ALU driven by the arbiter's alu_op/rd1/rd2.
    always_comb begin
        bus_if.alu_wd = '0;
        case (bus_if.alu_op)
            ALU_ADD:  bus_if.alu_wd = bus_if.alu_rd1 + bus_if.alu_rd2;
            ALU_SUB:  bus_if.alu_wd = bus_if.alu_rd1 - bus_if.alu_rd2;
            ALU_XOR:  bus_if.alu_wd = bus_if.alu_rd1 ^ bus_if.alu_rd2;
            ALU_OR:   bus_if.alu_wd = bus_if.alu_rd1 | bus_if.alu_rd2;
            ALU_AND:  bus_if.alu_wd = bus_if.alu_rd1 & bus_if.alu_rd2;
            ALU_SLL:  bus_if.alu_wd = bus_if.alu_rd1 << bus_if.alu_rd2[4:0];
            ALU_SRA:  bus_if.alu_wd = $signed(bus_if.alu_rd1) >>> bus_if.alu_rd2[4:0];
            ALU_SRL:  bus_if.alu_wd = bus_if.alu_rd1 >> bus_if.alu_rd2[4:0];
            ALU_SLT:  bus_if.alu_wd = {31'd0, $signed(bus_if.alu_rd1) < $signed(bus_if.alu_rd2)};
            ALU_SLTU: bus_if.alu_wd = {31'd0, bus_if.alu_rd1 < bus_if.alu_rd2};
            default:  bus_if.alu_wd = '0;
        endcase
    end

    typedef struct {
        logic [1:0]  valid;
        logic [5:0]  op0;
        logic [31:0] a0;
        logic [31:0] b0;
        logic [3:0]  t0;
        logic [5:0]  op1;
        logic [31:0] a1;
        logic [31:0] b1;
        logic [3:0]  t1;
        logic        rr;
        logic [1:0]  e_rdy;
        logic        e_vld;
        logic [31:0] e_data;
        logic        e_id;
        logic [3:0]  e_tag;
        logic        e_err;
    } vec_t;

    vec_t vq[$];
    int   checks;
    int   failures;

    function automatic vec_t mk(
        input logic [1:0] valid,
        input logic [5:0] op0, input logic [31:0] a0, input logic [31:0] b0, input logic [3:0] t0,
        input logic [5:0] op1, input logic [31:0] a1, input logic [31:0] b1, input logic [3:0] t1,
        input logic rr, input logic [1:0] e_rdy, input logic e_vld, input logic [31:0] e_data,
        input logic e_id, input logic [3:0] e_tag, input logic e_err);
        vec_t v;
        v.valid = valid; v.op0 = op0; v.a0 = a0; v.b0 = b0; v.t0 = t0;
        v.op1 = op1; v.a1 = a1; v.b1 = b1; v.t1 = t1; v.rr = rr;
        v.e_rdy = e_rdy; v.e_vld = e_vld; v.e_data = e_data;
        v.e_id = e_id; v.e_tag = e_tag; v.e_err = e_err;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", nm, act, exp);
        end
    endtask

    task automatic apply(input vec_t v);
        bus_if.req_valid = v.valid;
        bus_if.req_op    = {v.op1, v.op0};
        bus_if.req_a     = {v.a1, v.a0};
        bus_if.req_b     = {v.b1, v.b0};
        bus_if.req_tag   = {v.t1, v.t0};
        bus_if.res_ready = v.rr;
    endtask

    task automatic chk_res(input string pfx, input logic vld, input logic [31:0] data,
                           input logic id, input logic [3:0] tag, input logic err);
        chk({pfx, "_valid"}, 32'(bus_if.res_valid), 32'(vld));
        chk({pfx, "_data"},  bus_if.res_data, data);
        chk({pfx, "_id"},    32'(bus_if.res_id), 32'(id));
        chk({pfx, "_tag"},   32'(bus_if.res_tag), 32'(tag));
        chk({pfx, "_err"},   32'(bus_if.res_err), 32'(err));
    endtask

    initial begin
        checks   = 0;
        failures = 0;

        //         valid op0 a0            b0     t0    op1 a1            b1     t1    rr  rdy   vld data           id t     err
        vq.push_back(mk(2'b01, 1, 32'd5,        32'd7,  4'h3, 0, 32'd0,        32'd0,  4'h0, 1, 2'b01, 1, 32'd12,        0, 4'h3, 0));
        vq.push_back(mk(2'b10, 0, 32'd0,        32'd0,  4'h0, 2, 32'd3,        32'd5,  4'h9, 1, 2'b10, 1, 32'hFFFF_FFFE, 1, 4'h9, 0));
        vq.push_back(mk(2'b11, 3, 32'hF0,       32'h0F, 4'h1, 4, 32'h100,      32'd1,  4'h2, 1, 2'b01, 1, 32'hFF,        0, 4'h1, 0));
        vq.push_back(mk(2'b11, 5, 32'hFF,       32'h0F, 4'h4, 4, 32'h100,      32'd1,  4'h2, 1, 2'b10, 1, 32'h101,       1, 4'h2, 0));
        vq.push_back(mk(2'b11, 5, 32'hFF,       32'h0F, 4'h4, 6, 32'd1,        32'd4,  4'h5, 1, 2'b01, 1, 32'h0F,        0, 4'h4, 0));
        vq.push_back(mk(2'b11, 7, 32'h8000_0000, 32'd4, 4'h6, 6, 32'd1,        32'd4,  4'h5, 1, 2'b10, 1, 32'h10,        1, 4'h5, 0));
        vq.push_back(mk(2'b11, 7, 32'h8000_0000, 32'd4, 4'h6, 6, 32'd1,        32'd4,  4'h5, 0, 2'b00, 1, 32'h10,        1, 4'h5, 0));
        vq.push_back(mk(2'b11, 7, 32'h8000_0000, 32'd4, 4'h6, 6, 32'd1,        32'd4,  4'h5, 0, 2'b00, 1, 32'h10,        1, 4'h5, 0));
        vq.push_back(mk(2'b11, 7, 32'h8000_0000, 32'd4, 4'h6, 6, 32'd1,        32'd4,  4'h5, 0, 2'b00, 1, 32'h10,        1, 4'h5, 0));
        vq.push_back(mk(2'b11, 7, 32'h8000_0000, 32'd4, 4'h6, 6, 32'd1,        32'd4,  4'h5, 1, 2'b01, 1, 32'hF800_0000, 0, 4'h6, 0));
        vq.push_back(mk(2'b10, 0, 32'd0,        32'd0,  4'h0, 6, 32'd1,        32'd4,  4'h5, 1, 2'b10, 1, 32'h10,        1, 4'h5, 0));
        vq.push_back(mk(2'b10, 0, 32'd0,        32'd0,  4'h0, 0, 32'd1,        32'd1,  4'h7, 1, 2'b10, 1, 32'd0,         1, 4'h7, 1));
        vq.push_back(mk(2'b01, 11, 32'd1,       32'd2,  4'h8, 0, 32'd0,        32'd0,  4'h0, 1, 2'b01, 1, 32'd0,         0, 4'h8, 1));
        vq.push_back(mk(2'b01, 9, 32'hFFFF_FFFF, 32'd1, 4'hA, 0, 32'd0,        32'd0,  4'h0, 1, 2'b01, 1, 32'd1,         0, 4'hA, 0));
        vq.push_back(mk(2'b01, 8, 32'h80,       32'd3,  4'hB, 0, 32'd0,        32'd0,  4'h0, 1, 2'b01, 1, 32'h10,        0, 4'hB, 0));
        vq.push_back(mk(2'b00, 0, 32'd0,        32'd0,  4'h0, 0, 32'd0,        32'd0,  4'h0, 1, 2'b00, 0, 32'h10,        0, 4'hB, 0));
        vq.push_back(mk(2'b00, 0, 32'd0,        32'd0,  4'h0, 0, 32'd0,        32'd0,  4'h0, 0, 2'b00, 0, 32'h10,        0, 4'hB, 0));
        vq.push_back(mk(2'b01, 1, 32'hFFFF_FFFF, 32'd3, 4'hC, 0, 32'd0,        32'd0,  4'h0, 0, 2'b01, 1, 32'd2,         0, 4'hC, 0));
        vq.push_back(mk(2'b11, 1, 32'd2,        32'd2,  4'hD, 2, 32'd9,        32'd4,  4'hE, 0, 2'b00, 1, 32'd2,         0, 4'hC, 0));

        // Reset with both requesters active and the result port ready.
        rst = 1'b1;
        bus_if.req_valid = 2'b11;
        bus_if.req_op    = {6'd1, 6'd2};
        bus_if.req_a     = {32'd11, 32'd22};
        bus_if.req_b     = {32'd33, 32'd44};
        bus_if.req_tag   = {4'h5, 4'hA};
        bus_if.res_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk_res("reset", 1'b0, 32'd0, 1'b0, 4'h0, 1'b0);
        @(negedge clk);
        #1;
        chk("reset_ready", 32'(bus_if.req_ready), 32'd0);

        for (int i = 0; i < vq.size(); i++) begin
            @(negedge clk);
            rst = 1'b0;
            apply(vq[i]);
            #1;
            chk($sformatf("v%0d_ready", i), 32'(bus_if.req_ready), 32'(vq[i].e_rdy));
            if (vq[i].e_rdy == 2'b00) begin
                chk($sformatf("v%0d_idle_op", i), 32'(bus_if.alu_op), 32'd0);
                chk($sformatf("v%0d_idle_rd1", i), bus_if.alu_rd1, 32'd0);
            end else if (vq[i].e_rdy == 2'b01) begin
                chk($sformatf("v%0d_rd1", i), bus_if.alu_rd1, vq[i].a0);
            end else begin
                chk($sformatf("v%0d_rd1", i), bus_if.alu_rd1, vq[i].a1);
            end
            @(posedge clk);
            #1;
            chk_res($sformatf("v%0d", i), vq[i].e_vld, vq[i].e_data, vq[i].e_id, vq[i].e_tag, vq[i].e_err);
        end

        // Reset while a result is stalled and both requesters wait; pointer was 1 before it.
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk("midrst_ready", 32'(bus_if.req_ready), 32'd0);
        @(posedge clk);
        #1;
        chk_res("midrst", 1'b0, 32'd0, 1'b0, 4'h0, 1'b0);

        @(negedge clk);
        rst = 1'b0;
        bus_if.res_ready = 1'b1;
        #1;
        chk("postrst0_ready", 32'(bus_if.req_ready), 32'd1);
        @(posedge clk);
        #1;
        chk_res("postrst0", 1'b1, 32'd4, 1'b0, 4'hD, 1'b0);

        @(negedge clk);
        bus_if.req_valid = 2'b10;
        #1;
        chk("postrst1_ready", 32'(bus_if.req_ready), 32'd2);
        @(posedge clk);
        #1;
        chk_res("postrst1", 1'b1, 32'd5, 1'b1, 4'hE, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
